// File: rtl/ir_capture_sequencer.sv
// IR beam-break capture sequencer: conditions the raw IR line, then freezes one
// frame from camera A and one from camera B, holds them for display and re-arms.
module ir_capture_sequencer #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int TIMEOUT_CYCLES  = 2_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ir_in,
  input  logic       arm_in,
  input  logic       sel_in,
  input  logic       frame_done_a_in,
  input  logic       frame_done_b_in,
  output logic       cam_sel_out,
  output logic       freeze_a_out,
  output logic       freeze_b_out,
  output logic       busy_out,
  output logic       capture_done_out,
  output logic       timeout_out,
  output logic [7:0] event_count_out,
  output logic [2:0] state_out
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAP_A = 3'd1,
    CAP_B = 3'd2,
    HOLD  = 3'd3,
    REARM = 3'd4
  } state_t;

  logic            sync1;
  logic            ir_sync;
  logic            ir_db;
  logic            ir_db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            trig;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [HD_W-1:0] hold_cnt;
  logic            cam_sel;
  logic            freeze_a;
  logic            freeze_b;
  logic            capture_done;
  logic            timeout;
  logic [7:0]      event_count;

  // Synchronizer, debounce counter and edge history of the debounced level.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1      <= 1'b0;
      ir_sync    <= 1'b0;
      ir_db      <= 1'b0;
      ir_db_prev <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync1      <= ir_in;
      ir_sync    <= sync1;
      ir_db_prev <= ir_db;
      if (ir_sync != ir_db) begin
        if (db_cnt == DB_LAST) begin
          ir_db  <= ir_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign trig = ir_db & ~ir_db_prev;

  // Capture FSM with registered camera controls and status pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      to_cnt       <= '0;
      hold_cnt     <= '0;
      cam_sel      <= 1'b0;
      freeze_a     <= 1'b0;
      freeze_b     <= 1'b0;
      capture_done <= 1'b0;
      timeout      <= 1'b0;
      event_count  <= 8'd0;
    end else begin
      capture_done <= 1'b0;
      timeout      <= 1'b0;
      if ((state != IDLE) && !arm_in) begin
        // Disarm outranks frame pulses, timeouts and the hold expiry.
        state    <= IDLE;
        to_cnt   <= '0;
        hold_cnt <= '0;
        cam_sel  <= sel_in;
        freeze_a <= 1'b0;
        freeze_b <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            freeze_a <= 1'b0;
            freeze_b <= 1'b0;
            to_cnt   <= '0;
            hold_cnt <= '0;
            if (trig && arm_in) begin
              state       <= CAP_A;
              cam_sel     <= 1'b0;
              event_count <= event_count + 8'd1;
            end else begin
              cam_sel <= sel_in;
            end
          end
          CAP_A: begin
            if (frame_done_a_in) begin
              state    <= CAP_B;
              cam_sel  <= 1'b1;
              freeze_a <= 1'b1;
              to_cnt   <= '0;
            end else if (to_cnt == TO_LAST) begin
              state    <= REARM;
              cam_sel  <= sel_in;
              freeze_a <= 1'b0;
              freeze_b <= 1'b0;
              timeout  <= 1'b1;
              to_cnt   <= '0;
            end else begin
              cam_sel <= 1'b0;
              to_cnt  <= to_cnt + TO_W'(1);
            end
          end
          CAP_B: begin
            if (frame_done_b_in) begin
              state        <= HOLD;
              cam_sel      <= sel_in;
              freeze_b     <= 1'b1;
              capture_done <= 1'b1;
              to_cnt       <= '0;
              hold_cnt     <= '0;
            end else if (to_cnt == TO_LAST) begin
              state    <= REARM;
              cam_sel  <= sel_in;
              freeze_a <= 1'b0;
              freeze_b <= 1'b0;
              timeout  <= 1'b1;
              to_cnt   <= '0;
            end else begin
              cam_sel <= 1'b1;
              to_cnt  <= to_cnt + TO_W'(1);
            end
          end
          HOLD: begin
            cam_sel <= sel_in;
            if (hold_cnt == HD_LAST) begin
              state    <= REARM;
              freeze_a <= 1'b0;
              freeze_b <= 1'b0;
              hold_cnt <= '0;
            end else begin
              freeze_a <= 1'b1;
              freeze_b <= 1'b1;
              hold_cnt <= hold_cnt + HD_W'(1);
            end
          end
          REARM: begin
            // A beam that never clears keeps us here, so it cannot retrigger.
            cam_sel  <= sel_in;
            freeze_a <= 1'b0;
            freeze_b <= 1'b0;
            if (!ir_db) begin
              state <= IDLE;
            end else begin
              state <= REARM;
            end
          end
          default: begin
            state    <= IDLE;
            cam_sel  <= sel_in;
            freeze_a <= 1'b0;
            freeze_b <= 1'b0;
            to_cnt   <= '0;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign cam_sel_out      = cam_sel;
  assign freeze_a_out     = freeze_a;
  assign freeze_b_out     = freeze_b;
  assign busy_out         = (state != IDLE);
  assign capture_done_out = capture_done;
  assign timeout_out      = timeout;
  assign event_count_out  = event_count;
  assign state_out        = state;

endmodule

// File: doc/ir_capture_sequencer.md
# ir_capture_sequencer

Sequencer between the IR beam-break receiver and the two-camera capture path. It synchronizes and debounces the raw IR receiver line, and on an armed beam-break event freezes one complete frame from camera A, then one from camera B. It holds both frozen for a fixed display window, then re-arms. It drives the camera-select and per-camera freeze controls of the camera block, plus status for LEDs and seven-segment display.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 100_000: cycles the synchronized IR level must differ from the debounced level before it is accepted (1 ms at 100 MHz).
- `TIMEOUT_CYCLES`, default 2_000_000: maximum wait for a `frame_done` pulse in a capture state (20 ms).
- `HOLD_CYCLES`, default 100_000_000: cycles both frames stay frozen (1 s).

Ports:
- `clk_in`, input, 1: system clock (100 MHz). Only clock; every flop is on its rising edge.
- `rst_in`, input, 1: synchronous, active-high reset.
- `ir_in`, input, 1: raw, asynchronous IR receiver output. A rising edge means the beam is broken.
- `arm_in`, input, 1: level enable. Low aborts any activity.
- `sel_in`, input, 1: user display select, passed through while not capturing.
- `frame_done_a_in`, input, 1: one-cycle pulse at the end of each camera A frame.
- `frame_done_b_in`, input, 1: one-cycle pulse at the end of each camera B frame.
- `cam_sel_out`, output, 1: camera select to the camera block (0 = A, 1 = B). Registered.
- `freeze_a_out`, output, 1: freeze camera A frame buffer. Registered.
- `freeze_b_out`, output, 1: freeze camera B frame buffer. Registered.
- `busy_out`, output, 1: high whenever the FSM is not in IDLE.
- `capture_done_out`, output, 1: one-cycle pulse when both frames are frozen.
- `timeout_out`, output, 1: one-cycle pulse when a capture is abandoned.
- `event_count_out`, output, 8: count of accepted triggers, wraps 255→0.
- `state_out`, output, 3: FSM state code.

## Operation

Input conditioning:
- `ir_in` passes through a 2-flop synchronizer to give `ir_sync`.
- A debounce counter counts up while `ir_sync != ir_db` and clears when they are equal.
- On the cycle the counter reaches `DEBOUNCE_CYCLES-1` with the mismatch still present, `ir_db <= ir_sync` and the counter clears.
- `trig` = `ir_db` high this cycle and low on the previous cycle. It is a single-cycle pulse.

FSM states (encoding shown in parentheses):
- IDLE (0): `cam_sel_out = sel_in` (registered), both freezes low.
  - If `trig && arm_in`: go to CAP_A, increment `event_count_out`.
- CAP_A (1): `cam_sel_out = 0`, timeout counter runs.
  - On `frame_done_a_in`: set `freeze_a_out = 1`, go to CAP_B.
  - `frame_done_b_in` is ignored here.
- CAP_B (2): `cam_sel_out = 1`, timeout counter restarted from 0 on entry.
  - On `frame_done_b_in`: set `freeze_b_out = 1`, pulse `capture_done_out`, go to HOLD.
  - `frame_done_a_in` is ignored here.
- HOLD (3): both freezes high, `cam_sel_out = sel_in` so the user can flip between the two frozen frames.
  - After `HOLD_CYCLES` cycles: go to REARM.
- REARM (4): both freezes low, `cam_sel_out = sel_in`.
  - When `ir_db == 0`: go to IDLE. A beam that stays broken never retriggers.

Exceptions and boundaries:
- **Timeout:** in CAP_A or CAP_B, if the timeout counter reaches `TIMEOUT_CYCLES-1` without the expected pulse:
  - pulse `timeout_out`;
  - clear both freezes;
  - go to REARM.
- **Frame pulse vs. timeout:** a `frame_done` pulse on the same cycle as the timeout terminal count wins. There is no timeout.
- **Disarm:** `arm_in` low in any non-IDLE state forces IDLE on the next edge.
  - Both freezes clear.
  - No `capture_done_out` or `timeout_out` pulse.
  - Disarm has priority over every other transition.
- **Triggers outside IDLE** are ignored and not counted.
- **Trigger with `arm_in` low** in IDLE is ignored and not counted.
- **Counter widths:** `$clog2` of each parameter. Counters clear on every state entry.
- **Reset mid-operation:** returns to IDLE immediately with all outputs at reset values. `ir_db` clears, so a beam still broken after reset produces a trigger once it debounces high.

## Timing

- **Reset values:**
  - state IDLE; `ir_db`, synchronizer flops and all counters 0;
  - `cam_sel_out` 0, both freezes 0;
  - `busy_out` 0, `capture_done_out` 0, `timeout_out` 0;
  - `event_count_out` 0, `state_out` 0.
- **IR debounce:** `ir_db` rises `DEBOUNCE_CYCLES + 2` edges after `ir_in` rises, +1 for asynchronous sampling. Glitches shorter than `DEBOUNCE_CYCLES` are discarded.
- **Trigger to capture:** `trig` is asserted in the cycle after `ir_db` rises. State is CAP_A, and `cam_sel_out` = 0, one edge later.
- **Frame-done response:** `frame_done_x_in` sampled high at edge N gives the freeze output high and the next state visible after edge N.
- `capture_done_out` is high for exactly the first cycle of HOLD.
- **HOLD duration:** HOLD lasts exactly `HOLD_CYCLES` cycles.
- `state_out` and `busy_out` reflect the registered state.

## Test plan

Parameters for the bench: `DEBOUNCE_CYCLES=4`, `TIMEOUT_CYCLES=50`, `HOLD_CYCLES=20`.

- **Nominal capture.** Stimulus: `arm_in=1`, `ir_in` rises and stays high, `frame_done_a_in` pulse at +10 cycles, `frame_done_b_in` pulse at +10 more. Response:
  - `event_count_out=1`;
  - `freeze_a_out` then `freeze_b_out` go high;
  - single `capture_done_out` pulse;
  - freezes hold for 20 cycles;
  - REARM waits until `ir_in` drops, then IDLE.
- **Glitch rejection.** Stimulus: a 3-cycle `ir_in` pulse. Response: no trigger, `event_count_out=0`, state stays 0.
- **Timeout.** Stimulus: trigger, then `frame_done_a_in` pulses with no `frame_done_b_in`. Response:
  - `timeout_out` pulses 50 cycles after CAP_B entry;
  - both freezes low;
  - state 4;
  - no `capture_done_out`.
- **Wrong-camera pulse.** Stimulus: in CAP_A, `frame_done_b_in` arrives first. Response: ignored, state stays 1 until `frame_done_a_in`.
- **Disarm mid-capture.** Stimulus: drop `arm_in` in HOLD. Response:
  - IDLE next cycle;
  - freezes low;
  - no pulses;
  - a retrigger while `arm_in=0` leaves the count unchanged.
- **Wrap and reset.** Stimulus: 256 complete capture cycles. Response: `event_count_out` wraps to 0. Then `rst_in` asserted in CAP_B clears every output on the next edge.
